// File: rtl/placer_pkg.sv
// Shared types and packing helpers for the systolic page placer result path.
// The RESULT_CHECKSUM_EN macro (see placer_result_writer) uses the CHECKSUM state.
package placer_pkg;

   localparam int BRAM_ADDR_W = 13;
   localparam int BRAM_DATA_W = 32;

   localparam int OVF_BIT   = 31;
   localparam int COUNT_LSB = 0;
   localparam int COUNT_W   = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RUN      = 3'd1,
      HEADER   = 3'd2,
      CHECKSUM = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Fields arrive zero-extended, so {id, x, y} ends up right-aligned.
   function automatic logic [BRAM_DATA_W-1:0] pack_entry(
      input logic [BRAM_DATA_W-1:0] id,
      input logic [BRAM_DATA_W-1:0] x,
      input logic [BRAM_DATA_W-1:0] y,
      input int unsigned            coord_w
   );
      return (id << (2 * coord_w)) | (x << coord_w) | y;
   endfunction

   function automatic logic [BRAM_DATA_W-1:0] pack_header(
      input logic               ovf,
      input logic [COUNT_W-1:0] count
   );
      logic [BRAM_DATA_W-1:0] w;
      w = '0;
      w[OVF_BIT] = ovf;
      w[COUNT_LSB +: COUNT_W] = count;
      return w;
   endfunction

endpackage

// File: rtl/result_pack.sv
// Combinational packer turning one placement {id, x, y} into a BRAM entry word.
module result_pack
   import placer_pkg::*;
#(
   parameter int ID_W    = 8,
   parameter int COORD_W = 8
) (
   input  logic [ID_W-1:0]        i_id,
   input  logic [COORD_W-1:0]     i_x,
   input  logic [COORD_W-1:0]     i_y,
   output logic [BRAM_DATA_W-1:0] o_word
);

   assign o_word = pack_entry(BRAM_DATA_W'(i_id), BRAM_DATA_W'(i_x),
                              BRAM_DATA_W'(i_y), COORD_W);

endmodule

// File: rtl/placer_result_writer.sv
// Writes placer results into BRAM, then a count/overflow header, then signals done.
// Define RESULT_CHECKSUM_EN to also write an XOR of all entries after the header.
module placer_result_writer
   import placer_pkg::*;
#(
   parameter logic [BRAM_ADDR_W-1:0] BASE_ADDR   = 13'd0,
   parameter int                     MAX_ENTRIES = 256,
   parameter int                     COORD_W     = 8,
   parameter int                     ID_W        = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   res_valid,
   output logic                   res_ready,
   input  logic [ID_W-1:0]        res_page_id,
   input  logic [COORD_W-1:0]     res_x,
   input  logic [COORD_W-1:0]     res_y,
   input  logic                   res_last,
   output logic                   done,
   input  logic                   ack,
   output logic [BRAM_ADDR_W-1:0] address,
   output logic [BRAM_DATA_W-1:0] data_out,
   output logic [3:0]             we,
   output logic                   ram_en,
   output logic                   ram_rst
);

   localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_ENTRIES);

   state_t                 r_state, w_next;
   logic [COUNT_W-1:0]     r_count;
   logic                   r_ovf;
   logic                   r_done;
   logic                   r_ready;
   logic [3:0]             r_we;
   logic                   r_ram_en;
   logic [BRAM_ADDR_W-1:0] r_addr;
   logic [BRAM_DATA_W-1:0] r_data;
   logic [BRAM_DATA_W-1:0] w_entry;
   logic                   w_accept;
   logic                   w_room;
`ifdef RESULT_CHECKSUM_EN
   localparam logic [BRAM_ADDR_W-1:0] CSUM_ADDR = BRAM_ADDR_W'(int'(BASE_ADDR) + MAX_ENTRIES + 1);
   logic [BRAM_DATA_W-1:0] r_csum;
`endif

   result_pack #(.ID_W(ID_W), .COORD_W(COORD_W)) u_pack (
      .i_id   (res_page_id),
      .i_x    (res_x),
      .i_y    (res_y),
      .o_word (w_entry)
   );

   assign w_accept = res_valid & r_ready;
   assign w_room   = (r_count < MAX_CNT);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, RUN: if (w_accept) w_next = res_last ? HEADER : RUN;
`ifdef RESULT_CHECKSUM_EN
         HEADER:    w_next = CHECKSUM;
`else
         HEADER:    w_next = DONE;
`endif
         CHECKSUM:  w_next = DONE;
         DONE:      if (ack && r_done) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_done   <= 1'b0;
         r_ready  <= 1'b0;
         r_we     <= 4'h0;
         r_ram_en <= 1'b0;
         r_addr   <= BASE_ADDR;
         r_data   <= '0;
`ifdef RESULT_CHECKSUM_EN
         r_csum   <= '0;
`endif
      end else begin
         r_state  <= w_next;
         // Ready is registered so it reads 0 while in reset and drops with the last beat.
         r_ready  <= (w_next == IDLE) || (w_next == RUN);
         r_we     <= 4'h0;
         r_ram_en <= 1'b0;
         case (r_state)
            IDLE, RUN: begin
               if (w_accept) begin
                  if (w_room) begin
                     r_we     <= 4'hF;
                     r_ram_en <= 1'b1;
                     r_addr   <= BASE_ADDR + 13'd1 + r_count[BRAM_ADDR_W-1:0];
                     r_data   <= w_entry;
                     r_count  <= r_count + 16'd1;
`ifdef RESULT_CHECKSUM_EN
                     r_csum   <= r_csum ^ w_entry;
`endif
                  end else begin
                     r_ovf <= 1'b1;
                  end
               end
            end
            HEADER: begin
               r_we     <= 4'hF;
               r_ram_en <= 1'b1;
               r_addr   <= BASE_ADDR;
               r_data   <= pack_header(r_ovf, r_count);
            end
`ifdef RESULT_CHECKSUM_EN
            CHECKSUM: begin
               r_we     <= 4'hF;
               r_ram_en <= 1'b1;
               r_addr   <= CSUM_ADDR;
               r_data   <= r_csum;
            end
`endif
            DONE: begin
               r_done <= 1'b1;
               if (ack && r_done) begin
                  r_done  <= 1'b0;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
                  r_csum  <= '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign res_ready = r_ready;
   assign done      = r_done;
   assign address   = r_addr;
   assign data_out  = r_data;
   assign we        = r_we;
   assign ram_en    = r_ram_en;
   assign ram_rst   = 1'b0;

endmodule

// File: tb/tb_placer_result_writer.sv
// Directed bench for placer_result_writer with a small BRAM model (MAX_ENTRIES=4).
module tb_placer_result_writer;

   localparam logic [31:0] SENT = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_page_id, res_x, res_y;
   logic        res_last;
   logic        done;
   logic        ack;
   logic [12:0] address;
   logic [31:0] data_out;
   logic [3:0]  we;
   logic        ram_en;
   logic        ram_rst;

   logic        clr;
   logic [31:0] mem [0:15];
   int          nwr = 0;
   int          checks = 0;
   int          fails  = 0;
   int          w0;

   placer_result_writer #(
      .BASE_ADDR(13'd0), .MAX_ENTRIES(4), .COORD_W(8), .ID_W(8)
   ) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
      .res_page_id(res_page_id), .res_x(res_x), .res_y(res_y), .res_last(res_last),
      .done(done), .ack(ack), .address(address), .data_out(data_out), .we(we),
      .ram_en(ram_en), .ram_rst(ram_rst)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= SENT;
      end else if (ram_en) begin
         nwr <= nwr + 1;
         if (we == 4'hF && address < 13'd16) mem[address[3:0]] <= data_out;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic beat(input logic [7:0] id, input logic [7:0] x, input logic [7:0] y,
                       input logic last);
      res_valid   = 1'b1;
      res_page_id = id;
      res_x       = x;
      res_y       = y;
      res_last    = last;
      @(negedge clk);
   endtask

   // Called one cycle after the last beat: header appears next, done after that.
   task automatic wait_done(input string tag);
      @(negedge clk);
      chk({tag, "_hdr_addr"}, 32'(address), 32'h0);
      chk({tag, "_done_early"}, 32'(done), 32'h0);
`ifdef RESULT_CHECKSUM_EN
      @(negedge clk);
      chk({tag, "_csum_addr"}, 32'(address), 32'h5);
      chk({tag, "_done_early2"}, 32'(done), 32'h0);
`endif
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'h1);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("ack_done_low", 32'(done), 32'h0);
      chk("ack_ready", 32'(res_ready), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clr = 1'b1; ack = 1'b0;
      res_valid = 1'b0; res_page_id = '0; res_x = '0; res_y = '0; res_last = 1'b0;
      #3;
      chk("rst_done",  32'(done), 32'h0);
      chk("rst_ready", 32'(res_ready), 32'h0);
      chk("rst_we",    32'(we), 32'h0);
      chk("rst_en",    32'(ram_en), 32'h0);
      chk("rst_addr",  32'(address), 32'h0);
      chk("rst_data",  data_out, 32'h0);
      chk("rst_ramrst", 32'(ram_rst), 32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0; clr = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("idle_ready", 32'(res_ready), 32'h1);

      // Basic 3-beat run
      w0 = nwr;
      beat(8'd1, 8'd2, 8'd3, 1'b0);
      chk("t1_we1", 32'(we), 32'hF);
      chk("t1_addr1", 32'(address), 32'h1);
      beat(8'd4, 8'd5, 8'd6, 1'b0);
      beat(8'd7, 8'd8, 8'd9, 1'b1);
      res_valid = 1'b0; res_last = 1'b0;
      chk("t1_ready_drop", 32'(res_ready), 32'h0);
      chk("t1_addr3", 32'(address), 32'h3);
      wait_done("t1");
      chk("t1_m1", mem[1], 32'h00010203);
      chk("t1_m2", mem[2], 32'h00040506);
      chk("t1_m3", mem[3], 32'h00070809);
      chk("t1_hdr", mem[0], 32'h00000003);
`ifdef RESULT_CHECKSUM_EN
      chk("t1_csum", mem[5], 32'h00020F0C);
      chk("t1_nwr", 32'(nwr - w0), 32'd5);
`else
      chk("t1_nwr", 32'(nwr - w0), 32'd4);
`endif
      @(negedge clk);
      chk("t1_done_hold", 32'(done), 32'h1);
      do_ack();

      // Single-beat run after ack
      beat(8'h11, 8'h22, 8'h33, 1'b1);
      res_valid = 1'b0; res_last = 1'b0;
      wait_done("t2");
      chk("t2_m1", mem[1], 32'h00112233);
      chk("t2_hdr", mem[0], 32'h00000001);
      do_ack();

      // Overflow: 6 beats into a 4-entry table
      w0 = nwr;
      for (int i = 0; i < 6; i++) begin
         chk("t3_ready", 32'(res_ready), 32'h1);
         beat(8'(8'h20 + i), 8'(i), 8'(i + 1), i == 5);
      end
      res_valid = 1'b0; res_last = 1'b0;
      wait_done("t3");
      chk("t3_m1", mem[1], 32'h00200001);
      chk("t3_m2", mem[2], 32'h00210102);
      chk("t3_m3", mem[3], 32'h00220203);
      chk("t3_m4", mem[4], 32'h00230304);
      chk("t3_hdr", mem[0], 32'h80000004);
`ifdef RESULT_CHECKSUM_EN
      chk("t3_nwr", 32'(nwr - w0), 32'd6);
`else
      chk("t3_m5", mem[5], SENT);
      chk("t3_nwr", 32'(nwr - w0), 32'd5);
`endif
      do_ack();

      // Asynchronous reset mid-run
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      beat(8'h31, 8'h01, 8'h01, 1'b0);
      beat(8'h32, 8'h02, 8'h02, 1'b0);
      rst = 1'b1;
      #1;
      chk("t4_we", 32'(we), 32'h0);
      chk("t4_en", 32'(ram_en), 32'h0);
      chk("t4_addr", 32'(address), 32'h0);
      chk("t4_data", data_out, 32'h0);
      chk("t4_ready", 32'(res_ready), 32'h0);
      chk("t4_done", 32'(done), 32'h0);
      res_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("t4_m1", mem[1], 32'h00310101);
      chk("t4_m2", mem[2], SENT);
      chk("t4_nohdr", mem[0], SENT);
      rst = 1'b0;
      @(negedge clk); @(negedge clk);
      beat(8'h40, 8'h04, 8'h04, 1'b1);
      res_valid = 1'b0; res_last = 1'b0;
      wait_done("t4");
      chk("t4_re_m1", mem[1], 32'h00400404);
      chk("t4_re_hdr", mem[0], 32'h00000001);
      do_ack();

      // Gapped valid with ack held high during RUN
      w0 = nwr;
      ack = 1'b1;
      beat(8'h51, 8'h05, 8'h01, 1'b0);
      res_valid = 1'b0;
      @(negedge clk);
      chk("t5_gap_we", 32'(we), 32'h0);
      beat(8'h52, 8'h05, 8'h02, 1'b1);
      res_valid = 1'b0; res_last = 1'b0;
      ack = 1'b0;
      wait_done("t5");
      chk("t5_m1", mem[1], 32'h00510501);
      chk("t5_m2", mem[2], 32'h00520502);
      chk("t5_hdr", mem[0], 32'h00000002);
`ifdef RESULT_CHECKSUM_EN
      chk("t5_nwr", 32'(nwr - w0), 32'd4);
`else
      chk("t5_nwr", 32'(nwr - w0), 32'd3);
`endif
      do_ack();

`ifdef RESULT_CHECKSUM_EN
      beat(8'h01, 8'h02, 8'h03, 1'b0);
      beat(8'h04, 8'h05, 8'h06, 1'b1);
      res_valid = 1'b0; res_last = 1'b0;
      wait_done("t6");
      chk("t6_csum", mem[5], 32'h00050705);
      do_ack();
`endif

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
